datapath_p: RTL and testbench

Parametrised multicycle MIPS datapath, successor to the fixed 8-bit datapath. Data width and register count are parameters. A built-in fetch sequencer assembles the 32-bit instruction from a BUSW-wide memory using a req/ack handshake, replacing controller-driven per-byte irwrite strobes. Data loads use the same handshake. The block sits between the multicycle controller and the memory model.

---
 rtl/datapath_pkg.sv | 31 +++
 rtl/datapath_p_if.sv | 15 +
 rtl/datapath_p_regfile.sv | 33 +++
 rtl/datapath_p.sv | 191 +++++++++++++++++++
 tb/tb_datapath_p.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared constants and types for the parametrised multicycle datapath:
// ALU opcodes, mux encodings, instruction field positions and sequencer states.
package datapath_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_ONE     = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PC_ALURESULT = 2'd0;
  localparam logic [1:0] PC_ALUOUT    = 2'd1;
  localparam logic [1:0] PC_JUMP      = 2'd2;
  localparam logic [1:0] PC_ZERO      = 2'd3;

  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_LOAD
  } seq_state_t;

endpackage

// File: rtl/datapath_p_if.sv
// Memory-side bus of the datapath: request/acknowledge handshake, address,
// store data and BUSW-wide read data.
interface datapath_p_if #(
  parameter int WIDTH = 8,
  parameter int BUSW  = 8
);
  logic             mem_req;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [BUSW-1:0]  memdata;
  logic             mem_ack;

  modport master (output mem_req, adr, writedata, input memdata, mem_ack);
  modport slave  (input mem_req, adr, writedata, output memdata, mem_ack);
endinterface

// File: rtl/datapath_p_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// register 0 reads as zero and ignores writes.
module regfile_p #(
  parameter int WIDTH = 8,
  parameter int NREG  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [$clog2(NREG)-1:0] ra1,
  input  logic [$clog2(NREG)-1:0] ra2,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic                    we,
  input  logic [WIDTH-1:0]        wd,
  output logic [WIDTH-1:0]        rd1,
  output logic [WIDTH-1:0]        rd2
);

  logic [WIDTH-1:0] regs [NREG];

  // NOTE: the array is cleared on reset, so it maps to flops rather than RAM;
  // non-blocking writes keep a same-cycle read returning the old value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/datapath_p.sv
// Multicycle MIPS datapath with a built-in fetch/load sequencer that assembles
// 32-bit instructions and data loads over a BUSW-wide req/ack memory bus.
module datapath_p
  import datapath_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 8,
  parameter int BUSW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         alucontrol,
  input  logic               alusrca,
  input  logic [1:0]         alusrcb,
  input  logic               iord,
  input  logic               memtoreg,
  input  logic               regdst,
  input  logic               regwrite,
  input  logic               pcen,
  input  logic [1:0]         pcsource,
  input  logic               fetch,
  input  logic               memread,
  datapath_p_if.master       mem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic               mem_done,
  output logic               busy,
  output logic               zero
);

  localparam int RA    = $clog2(NREG);
  localparam int BEATS = 32 / BUSW;

  seq_state_t state, state_next;

  logic [WIDTH-1:0] pc, a_reg, b_reg, aluout, data_reg, faddr, laddr;
  logic [WIDTH-1:0] imm, jump_target, srca, srcb, aluresult;
  logic [WIDTH-1:0] rd1, rd2, wd, pc_next, mem_addr;
  logic [RA-1:0]    rs, rt, rd, wa;
  logic [1:0]       beat;
  logic             fetch_done, accept_fetch, accept_load, last_beat;

  assign rs = instr[RS_LSB +: RA];
  assign rt = instr[RT_LSB +: RA];
  assign rd = instr[RD_LSB +: RA];

  assign imm         = WIDTH'({{16{instr[15]}}, instr[15:0]});
  assign jump_target = WIDTH'({instr[25:0], 2'b00});

  assign wa = regdst ? rt : rd;
  assign wd = memtoreg ? aluout : data_reg;

  regfile_p #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
    .clk (clk),
    .reset (reset),
    .ra1 (rs),
    .ra2 (rt),
    .wa  (wa),
    .we  (regwrite),
    .wd  (wd),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  assign srca = alusrca ? pc : a_reg;

  // NOTE: every always_comb output gets a default before the case so that no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    srcb = b_reg;
    case (alusrcb)
      SRCB_REG:     srcb = b_reg;
      SRCB_ONE:     srcb = WIDTH'(1);
      SRCB_IMM:     srcb = imm;
      SRCB_IMM_SH2: srcb = imm << 2;
      default:      srcb = b_reg;
    endcase
  end

  always_comb begin
    aluresult = '0;
    case (alucontrol)
      ALU_ADD: aluresult = srca + srcb;
      ALU_SUB: aluresult = srca - srcb;
      ALU_AND: aluresult = srca & srcb;
      ALU_OR:  aluresult = srca | srcb;
      ALU_SLT: aluresult = ($signed(srca) < $signed(srcb)) ? WIDTH'(1) : '0;
      default: aluresult = '0;
    endcase
  end

  assign zero = (aluresult == '0);

  always_comb begin
    pc_next = aluresult;
    case (pcsource)
      PC_ALURESULT: pc_next = aluresult;
      PC_ALUOUT:    pc_next = aluout;
      PC_JUMP:      pc_next = jump_target;
      PC_ZERO:      pc_next = '0;
      default:      pc_next = aluresult;
    endcase
  end

  assign mem_addr  = iord ? pc : aluout;
  assign last_beat = (beat == 2'(BEATS - 1));

  // Sequencer next state and bus drive; fetch wins over memread in IDLE.
  always_comb begin
    state_next   = state;
    mem.mem_req  = 1'b0;
    mem.adr      = mem_addr;
    accept_fetch = 1'b0;
    accept_load  = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (fetch) begin
          accept_fetch = 1'b1;
          state_next   = SEQ_FETCH;
        end else if (memread) begin
          accept_load = 1'b1;
          state_next  = SEQ_LOAD;
        end
      end
      SEQ_FETCH: begin
        mem.mem_req = 1'b1;
        mem.adr     = faddr + WIDTH'(beat);
        if (mem.mem_ack && last_beat) state_next = SEQ_IDLE;
      end
      SEQ_LOAD: begin
        mem.mem_req = 1'b1;
        mem.adr     = laddr;
        if (mem.mem_ack) state_next = SEQ_IDLE;
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  assign busy          = (state != SEQ_IDLE);
  assign mem.writedata = b_reg;

  always_ff @(posedge clk) begin
    if (!reset) state <= SEQ_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      aluout      <= '0;
      data_reg    <= '0;
      faddr       <= '0;
      laddr       <= '0;
      beat        <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_done  <= 1'b0;
      mem_done    <= 1'b0;
    end else begin
      a_reg      <= rd1;
      b_reg      <= rd2;
      aluout     <= aluresult;
      fetch_done <= (state == SEQ_FETCH) && mem.mem_ack && last_beat;
      mem_done   <= (state == SEQ_LOAD) && mem.mem_ack;
      if (pcen) pc <= pc_next;

      // Valid rises one cycle after the final beat; a new fetch clears it first.
      if (accept_fetch) begin
        faddr       <= pc;
        beat        <= '0;
        instr_valid <= 1'b0;
      end else if (fetch_done) begin
        instr_valid <= 1'b1;
      end

      if (accept_load) laddr <= mem_addr;

      if (state == SEQ_FETCH && mem.mem_ack) begin
        for (int b = 0; b < BEATS; b++) begin
          if (beat == 2'(b)) instr[31 - b*BUSW -: BUSW] <= mem.memdata;
        end
        beat <= beat + 2'd1;
      end

      if (state == SEQ_LOAD && mem.mem_ack) data_reg <= WIDTH'(mem.memdata);
    end
  end

endmodule

// File: tb/tb_datapath_p.sv
// Directed bench for datapath_p: an 8-bit/8-bit-bus instance and a
// 16-bit/16-bit-bus instance, each with a small behavioural memory.
module tb_datapath_p;
  import datapath_pkg::*;

  typedef struct packed {
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       pcen;
    logic [1:0] pcsource;
    logic       fetch;
    logic       memread;
  } ctrl_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
    logic       z;
  } alu_vec_t;

  localparam int NV = 10;

  logic        clk;
  logic        reset;
  ctrl_t       ctl8, ctl16;
  logic        ack8, ack16;
  logic [31:0] instr8, instr16;
  logic        iv8, iv16, md8, md16, busy8, busy16, zero8, zero16;
  logic [7:0]  mem8  [256];
  logic [15:0] mem16 [16];
  logic [7:0]  pc8;
  alu_vec_t    vecs [NV];
  int          n_vec = 0;
  int          n_bad = 0;
  int          busy_cnt;

  datapath_p_if #(.WIDTH(8),  .BUSW(8))  if8  ();
  datapath_p_if #(.WIDTH(16), .BUSW(16)) if16 ();

  assign if8.memdata  = mem8[if8.adr];
  assign if8.mem_ack  = ack8;
  assign if16.memdata = mem16[if16.adr[3:0]];
  assign if16.mem_ack = ack16;

  datapath_p #(.WIDTH(8), .NREG(8), .BUSW(8)) d8 (
    .clk (clk), .reset (reset),
    .alucontrol (ctl8.alucontrol), .alusrca (ctl8.alusrca), .alusrcb (ctl8.alusrcb),
    .iord (ctl8.iord), .memtoreg (ctl8.memtoreg), .regdst (ctl8.regdst),
    .regwrite (ctl8.regwrite), .pcen (ctl8.pcen), .pcsource (ctl8.pcsource),
    .fetch (ctl8.fetch), .memread (ctl8.memread), .mem (if8),
    .instr (instr8), .instr_valid (iv8), .mem_done (md8), .busy (busy8), .zero (zero8)
  );

  datapath_p #(.WIDTH(16), .NREG(8), .BUSW(16)) d16 (
    .clk (clk), .reset (reset),
    .alucontrol (ctl16.alucontrol), .alusrca (ctl16.alusrca), .alusrcb (ctl16.alusrcb),
    .iord (ctl16.iord), .memtoreg (ctl16.memtoreg), .regdst (ctl16.regdst),
    .regwrite (ctl16.regwrite), .pcen (ctl16.pcen), .pcsource (ctl16.pcsource),
    .fetch (ctl16.fetch), .memread (ctl16.memread), .mem (if16),
    .instr (instr16), .instr_valid (iv16), .mem_done (md16), .busy (busy16), .zero (zero16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Place w at pc8 (MSB byte first), start a fetch and wait for instr_valid.
  task automatic fetch8(input logic [31:0] w);
    int n;
    for (int k = 0; k < 4; k++) mem8[pc8 + 8'(k)] = w[31 - 8*k -: 8];
    ctl8.fetch = 1'b1;
    tick();
    ctl8.fetch = 1'b0;
    n = 0;
    while (!iv8 && n < 20) begin
      tick();
      n++;
    end
    check("fetch8 completes", {31'b0, iv8}, 32'd1);
  endtask

  // Load register r with v through the ALU: r0 + imm, then write back to rt.
  task automatic setreg8(input logic [4:0] r, input logic [7:0] v);
    fetch8({6'h08, 5'd0, r, 8'h00, v});
    ctl8            = '0;
    ctl8.alusrcb    = SRCB_IMM;
    ctl8.alucontrol = ALU_ADD;
    tick();
    ctl8.regwrite = 1'b1;
    ctl8.memtoreg = 1'b1;
    ctl8.regdst   = 1'b1;
    tick();
    ctl8 = '0;
  endtask

  initial begin
    vecs[0] = '{8'h7F, 8'h01, ALU_ADD, 8'h80, 1'b0};
    vecs[1] = '{8'h05, 8'h05, ALU_SUB, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, ALU_SLT, 8'h01, 1'b0};
    vecs[3] = '{8'h01, 8'hFF, ALU_SLT, 8'h00, 1'b1};
    vecs[4] = '{8'hF0, 8'h3C, ALU_AND, 8'h30, 1'b0};
    vecs[5] = '{8'hF0, 8'h0C, ALU_OR,  8'hFC, 1'b0};
    vecs[6] = '{8'hFF, 8'h01, ALU_ADD, 8'h00, 1'b1};
    vecs[7] = '{8'h00, 8'h01, ALU_SUB, 8'hFF, 1'b0};
    vecs[8] = '{8'h80, 8'h7F, ALU_SLT, 8'h01, 1'b0};
    vecs[9] = '{8'h55, 8'h0F, 3'b011,  8'h00, 1'b1};

    ctl8  = '0;
    ctl16 = '0;
    ack8  = 1'b1;
    ack16 = 1'b1;
    pc8   = 8'h00;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    check("rst busy8",     {31'b0, busy8},       32'd0);
    check("rst valid8",    {31'b0, iv8},         32'd0);
    check("rst mem_done8", {31'b0, md8},         32'd0);
    check("rst mem_req8",  {31'b0, if8.mem_req}, 32'd0);
    check("rst instr8",    instr8,               32'd0);
    check("rst aluout8",   {24'b0, if8.adr},     32'd0);
    check("rst instr16",   instr16,              32'd0);

    // 16-bit bus fetch with beat 1 stalled for three cycles.
    mem16[0] = 16'h1234;
    mem16[1] = 16'hABCD;
    ctl16.fetch = 1'b1;
    tick();
    ctl16.fetch = 1'b0;
    busy_cnt = 0;
    check("f16 beat0 adr", {16'b0, if16.adr}, 32'd0);
    busy_cnt += int'(busy16);
    tick();
    ack16 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("f16 stall mem_req", {31'b0, if16.mem_req}, 32'd1);
      check("f16 stall adr",     {16'b0, if16.adr},     32'd1);
      busy_cnt += int'(busy16);
      tick();
    end
    ack16 = 1'b1;
    busy_cnt += int'(busy16);
    tick();
    busy_cnt += int'(busy16);
    check("f16 busy cycles", 32'(busy_cnt), 32'd5);
    tick();
    check("f16 valid", {31'b0, iv16}, 32'd1);
    check("f16 instr", instr16, 32'h1234ABCD);

    // Sign-extended immediate on the 16-bit datapath, plain and shifted.
    mem16[0] = 16'h0000;
    mem16[1] = 16'hFFF0;
    ctl16.fetch = 1'b1;
    tick();
    ctl16.fetch = 1'b0;
    for (int n = 0; n < 20 && !iv16; n++) tick();
    check("imm16 fetch valid", {31'b0, iv16}, 32'd1);
    ctl16.alusrcb    = SRCB_IMM;
    ctl16.alucontrol = ALU_ADD;
    tick();
    check("imm16 sel2", {16'b0, if16.adr}, 32'h0000FFF0);
    ctl16.alusrcb = SRCB_IMM_SH2;
    tick();
    check("imm16 sel3", {16'b0, if16.adr}, 32'h0000FFC0);
    ctl16 = '0;

    // Step pc to 0x10 via pc + 1, then fetch 8C A3 00 04 there.
    ctl8.alusrca    = 1'b1;
    ctl8.alusrcb    = SRCB_ONE;
    ctl8.alucontrol = ALU_ADD;
    ctl8.pcsource   = PC_ALURESULT;
    ctl8.pcen       = 1'b1;
    repeat (16) tick();
    ctl8      = '0;
    ctl8.iord = 1'b1;
    pc8       = 8'h10;
    #1;
    check("pc stepped", {24'b0, if8.adr}, 32'h10);
    ctl8 = '0;
    mem8[8'h10] = 8'h8C;
    mem8[8'h11] = 8'hA3;
    mem8[8'h12] = 8'h00;
    mem8[8'h13] = 8'h04;
    ctl8.fetch = 1'b1;
    tick();
    ctl8.fetch = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("f8 adr",     {24'b0, if8.adr},     32'(16 + k));
      check("f8 mem_req", {31'b0, if8.mem_req}, 32'd1);
      tick();
    end
    check("f8 idle after last beat", {31'b0, busy8}, 32'd0);
    check("f8 valid not yet",        {31'b0, iv8},   32'd0);
    tick();
    check("f8 valid", {31'b0, iv8}, 32'd1);
    check("f8 instr", instr8,       32'h8CA30004);

    // ALU table: r1 = a, r2 = b, instruction rs=1 rt=2.
    for (int i = 0; i < NV; i++) begin
      setreg8(5'd1, vecs[i].a);
      setreg8(5'd2, vecs[i].b);
      fetch8({6'h00, 5'd1, 5'd2, 5'd3, 11'h020});
      ctl8.alucontrol = vecs[i].op;
      ctl8.alusrcb    = SRCB_REG;
      #1;
      check($sformatf("alu[%0d] zero", i), {31'b0, zero8}, {31'b0, vecs[i].z});
      tick();
      check($sformatf("alu[%0d] result", i), {24'b0, if8.adr},       {24'b0, vecs[i].y});
      check($sformatf("alu[%0d] regB", i),   {24'b0, if8.writedata}, {24'b0, vecs[i].b});
      ctl8 = '0;
    end

    // Data load from aluout = 0x24, then write it back to r3.
    fetch8({6'h23, 5'd0, 5'd3, 16'h0024});
    mem8[8'h24]     = 8'h5A;
    ctl8.alusrcb    = SRCB_IMM;
    ctl8.alucontrol = ALU_ADD;
    tick();
    check("load idle adr", {24'b0, if8.adr}, 32'h24);
    ctl8.memread = 1'b1;
    tick();
    ctl8.memread = 1'b0;
    check("load busy",    {31'b0, busy8},       32'd1);
    check("load mem_req", {31'b0, if8.mem_req}, 32'd1);
    check("load adr",     {24'b0, if8.adr},     32'h24);
    check("load no done", {31'b0, md8},         32'd0);
    tick();
    check("load done",      {31'b0, md8},   32'd1);
    check("load idle",      {31'b0, busy8}, 32'd0);
    tick();
    check("load done pulse", {31'b0, md8},  32'd0);
    ctl8          = '0;
    ctl8.regwrite = 1'b1;
    ctl8.regdst   = 1'b1;
    tick();
    ctl8 = '0;
    check("r3 old on write edge", {24'b0, if8.writedata}, 32'h00);
    tick();
    check("r3 loaded", {24'b0, if8.writedata}, 32'h5A);

    // Write 0xAA to r0: it must still read zero.
    fetch8({6'h08, 5'd0, 5'd0, 16'h00AA});
    ctl8.alusrcb    = SRCB_IMM;
    ctl8.alucontrol = ALU_ADD;
    tick();
    check("r0 wdata", {24'b0, if8.adr}, 32'hAA);
    ctl8.regwrite = 1'b1;
    ctl8.memtoreg = 1'b1;
    ctl8.regdst   = 1'b1;
    tick();
    ctl8 = '0;
    tick();
    check("r0 reads zero", {24'b0, if8.writedata}, 32'h00);

    // Jump target {0x12, 2'b00} = 0x48, then pcsource 3 clears pc.
    fetch8({6'h02, 26'h0000012});
    ctl8.pcen     = 1'b1;
    ctl8.pcsource = PC_JUMP;
    tick();
    ctl8      = '0;
    ctl8.iord = 1'b1;
    #1;
    check("pc jump", {24'b0, if8.adr}, 32'h48);
    ctl8.pcen     = 1'b1;
    ctl8.pcsource = PC_ZERO;
    tick();
    ctl8.pcen = 1'b0;
    pc8       = 8'h00;
    check("pc zero", {24'b0, if8.adr}, 32'h00);
    ctl8 = '0;

    // Reset during beat 2 aborts the fetch.
    mem8[8'h00] = 8'hDE;
    mem8[8'h01] = 8'hAD;
    mem8[8'h02] = 8'hBE;
    mem8[8'h03] = 8'hEF;
    ctl8.fetch = 1'b1;
    tick();
    ctl8.fetch = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort busy",    {31'b0, busy8},       32'd0);
    check("abort instr",   instr8,               32'd0);
    check("abort valid",   {31'b0, iv8},         32'd0);
    check("abort mem_req", {31'b0, if8.mem_req}, 32'd0);

    // fetch and memread together: only the fetch runs.
    ctl8.fetch   = 1'b1;
    ctl8.memread = 1'b1;
    tick();
    ctl8 = '0;
    for (int k = 0; k < 4; k++) begin
      check("prio fetch adr", {24'b0, if8.adr}, 32'(k));
      check("prio no done",   {31'b0, md8},     32'd0);
      tick();
    end
    tick();
    check("prio valid",   {31'b0, iv8},   32'd1);
    check("prio instr",   instr8,         32'hDEADBEEF);
    check("prio idle",    {31'b0, busy8}, 32'd0);
    check("prio no load", {31'b0, md8},   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
